// File: rtl/random_word_server_if.sv
// Bus between the randomness extractor / word consumer and random_word_server.
interface random_word_server_if #(
  parameter int WORD_W = 32
);
  logic [511:0]      key_in;
  logic              key_ready;
  logic              word_req;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic [6:0]        words_left;
  logic              need_key;
  logic              underflow;
  logic              key_dropped;

  modport master (
    output key_in, key_ready, word_req,
    input  word_out, word_valid, words_left, need_key, underflow, key_dropped
  );

  modport slave (
    input  key_in, key_ready, word_req,
    output word_out, word_valid, words_left, need_key, underflow, key_dropped
  );
endinterface

// File: rtl/random_word_server.sv
// Random word server: captures a 512-bit extracted key into a pool and hands
// it out one word per request, LSB word first, zeroizing each served word.
module random_word_server #(
  parameter int WORD_W = 32
) (
  input logic                  clock,
  input logic                  reset,
  random_word_server_if.slave  bus
);
  localparam int N_WORDS = 512 / WORD_W;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_LOADED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [511:0]      pool_q, pool_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [6:0]        words_left_q, words_left_d;
  logic [WORD_W-1:0] word_out_q, word_out_d;
  logic              word_valid_q, word_valid_d;
  logic              underflow_q, underflow_d;
  logic              key_dropped_q, key_dropped_d;
  logic              key_ready_q;
  logic              key_edge;

  // Next-state logic: key capture, word serving with zeroization, event pulses.
  always_comb begin
    state_d       = state_q;
    pool_d        = pool_q;
    index_d       = index_q;
    words_left_d  = words_left_q;
    word_out_d    = word_out_q;
    word_valid_d  = 1'b0;
    underflow_d   = 1'b0;
    key_dropped_d = 1'b0;
    key_edge      = bus.key_ready & ~key_ready_q;

    case (state_q)
      ST_EMPTY: begin
        if (key_edge) begin
          pool_d       = bus.key_in;
          index_d      = '0;
          words_left_d = 7'(N_WORDS);
          state_d      = ST_LOADED;
        end else begin
          state_d = ST_EMPTY;
        end
        // A request against an empty pool is flagged even if a key lands now.
        if (bus.word_req) begin
          underflow_d = 1'b1;
        end else begin
          underflow_d = 1'b0;
        end
      end
      ST_LOADED: begin
        if (bus.word_req) begin
          word_out_d   = pool_q[index_q*WORD_W +: WORD_W];
          word_valid_d = 1'b1;
          pool_d[index_q*WORD_W +: WORD_W] = '0;
          words_left_d = words_left_q - 7'd1;
          if (index_q == LAST_IDX) begin
            index_d = '0;
            state_d = ST_EMPTY;
          end else begin
            index_d = index_q + 1'b1;
          end
        end else begin
          word_valid_d = 1'b0;
        end
        // A fresh key cannot overwrite unserved material; it is dropped.
        if (key_edge) begin
          key_dropped_d = 1'b1;
        end else begin
          key_dropped_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_EMPTY;
        pool_d       = '0;
        index_d      = '0;
        words_left_d = 7'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset that zeroizes the pool.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      pool_q        <= '0;
      index_q       <= '0;
      words_left_q  <= 7'd0;
      word_out_q    <= '0;
      word_valid_q  <= 1'b0;
      underflow_q   <= 1'b0;
      key_dropped_q <= 1'b0;
      key_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pool_q        <= pool_d;
      index_q       <= index_d;
      words_left_q  <= words_left_d;
      word_out_q    <= word_out_d;
      word_valid_q  <= word_valid_d;
      underflow_q   <= underflow_d;
      key_dropped_q <= key_dropped_d;
      key_ready_q   <= bus.key_ready;
    end
  end

  assign bus.word_out    = word_out_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.words_left  = words_left_q;
  assign bus.underflow   = underflow_q;
  assign bus.key_dropped = key_dropped_q;
  assign bus.need_key    = (state_q == ST_EMPTY);
endmodule

// File: tb/tb_random_word_server.sv
// Directed bench for random_word_server at WORD_W = 32 and WORD_W = 8.
module tb_random_word_server;
  logic clock;
  logic reset;
  int   vectors;
  int   errs;

  random_word_server_if #(.WORD_W(32)) bus32 ();
  random_word_server_if #(.WORD_W(8))  bus8 ();

  random_word_server #(.WORD_W(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  random_word_server #(.WORD_W(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [511:0] key_a, key_b, key_c, key_f, key_8;

  initial begin
    vectors = 0;
    errs    = 0;
    reset   = 1'b1;
    bus32.key_in = '0; bus32.key_ready = 1'b0; bus32.word_req = 1'b0;
    bus8.key_in  = '0; bus8.key_ready  = 1'b0; bus8.word_req  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      key_a[i*32 +: 32] = 32'hA5A50000 + 32'(i);
      key_b[i*32 +: 32] = 32'hB0000000 + 32'(i);
      key_c[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
    end
    key_f = {512{1'b1}};
    for (int k = 0; k < 64; k++) key_8[k*8 +: 8] = 8'h40 - 8'(k);

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_words_left", 64'(bus32.words_left), 64'd0);
    check("rst_need_key",   64'(bus32.need_key),   64'd1);
    check("rst_word_valid", 64'(bus32.word_valid), 64'd0);
    check("rst_word_out",   64'(bus32.word_out),   64'd0);
    check("rst_underflow",  64'(bus32.underflow),  64'd0);
    check("rst_dropped",    64'(bus32.key_dropped),64'd0);

    // Request with empty pool
    bus32.word_req = 1'b1;
    tick();
    bus32.word_req = 1'b0;
    check("uf_pulse",      64'(bus32.underflow),  64'd1);
    check("uf_valid",      64'(bus32.word_valid), 64'd0);
    check("uf_need_key",   64'(bus32.need_key),   64'd1);
    check("uf_words_left", 64'(bus32.words_left), 64'd0);
    tick();
    check("uf_pulse_end",  64'(bus32.underflow),  64'd0);

    // Load key A and drain with back-to-back requests, key_ready held high
    bus32.key_in = key_a; bus32.key_ready = 1'b1;
    tick();
    check("a_loaded_left", 64'(bus32.words_left), 64'd16);
    check("a_need_key",    64'(bus32.need_key),   64'd0);
    bus32.word_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("a_valid", 64'(bus32.word_valid), 64'd1);
      check("a_word",  64'(bus32.word_out),   64'(32'hA5A50000 + 32'(i)));
      check("a_left",  64'(bus32.words_left), 64'(15 - i));
      check("a_need",  64'(bus32.need_key),   (i == 15) ? 64'd1 : 64'd0);
    end
    bus32.word_req = 1'b0;
    bus32.key_in   = key_b;
    tick();
    check("a_idle_valid", 64'(bus32.word_valid), 64'd0);
    check("a_hold_word",  64'(bus32.word_out),   64'h00000000A5A5000F);
    tick(); tick();
    check("hold_no_reload", 64'(bus32.words_left), 64'd0);
    check("hold_need_key",  64'(bus32.need_key),   64'd1);

    // Fresh edge loads key B; 16th request collides with another rising edge
    bus32.key_ready = 1'b0;
    tick();
    bus32.key_ready = 1'b1;
    tick();
    check("b_loaded_left", 64'(bus32.words_left), 64'd16);
    bus32.key_ready = 1'b0;
    bus32.word_req  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("b_word", 64'(bus32.word_out), 64'(32'hB0000000 + 32'(i)));
    end
    bus32.key_ready = 1'b1;
    bus32.key_in    = key_c;
    tick();
    bus32.word_req = 1'b0;
    check("b_last_valid", 64'(bus32.word_valid),  64'd1);
    check("b_last_word",  64'(bus32.word_out),    64'h00000000B000000F);
    check("b_dropped",    64'(bus32.key_dropped), 64'd1);
    check("b_need_key",   64'(bus32.need_key),    64'd1);
    check("b_left",       64'(bus32.words_left),  64'd0);
    tick();
    check("b_dropped_end", 64'(bus32.key_dropped), 64'd0);
    check("b_no_load",     64'(bus32.words_left),  64'd0);

    // Serve 5 words of key C, reset, then load all-ones key
    bus32.key_ready = 1'b0;
    tick();
    bus32.key_ready = 1'b1;
    tick();
    bus32.key_ready = 1'b0;
    check("c_loaded_left", 64'(bus32.words_left), 64'd16);
    bus32.word_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("c_word4", 64'(bus32.word_out),   64'h00000000C0DE0004);
    check("c_left",  64'(bus32.words_left), 64'd11);
    bus32.word_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_left", 64'(bus32.words_left), 64'd0);
    check("mid_rst_word", 64'(bus32.word_out),   64'd0);
    check("mid_rst_need", 64'(bus32.need_key),   64'd1);
    bus32.key_in = key_f; bus32.key_ready = 1'b1;
    tick();
    bus32.key_ready = 1'b0;
    check("f_loaded_left", 64'(bus32.words_left), 64'd16);
    bus32.word_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("f_word", 64'(bus32.word_out),   64'h00000000FFFFFFFF);
      check("f_left", 64'(bus32.words_left), 64'(15 - i));
    end
    bus32.word_req = 1'b0;

    // WORD_W = 8 instance: 64 words, MSB-first byte pattern served LSB first
    bus8.key_in = key_8; bus8.key_ready = 1'b1;
    tick();
    bus8.key_ready = 1'b0;
    check("w8_loaded_left", 64'(bus8.words_left), 64'd64);
    bus8.word_req = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      check("w8_valid", 64'(bus8.word_valid), 64'd1);
      check("w8_word",  64'(bus8.word_out),   64'(8'h40 - 8'(k)));
      check("w8_left",  64'(bus8.words_left), 64'(63 - k));
    end
    bus8.word_req = 1'b0;
    check("w8_need_key", 64'(bus8.need_key), 64'd1);
    tick();
    check("w8_idle_valid", 64'(bus8.word_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
